// File: rtl/limit_pkg.sv
// Shared constants, types and helpers for the limit-command frame receiver.
package limit_pkg;

    localparam logic [7:0] HDR0        = 8'hAA;
    localparam logic [7:0] HDR1        = 8'h55;
    localparam int         PAYLOAD_LEN = 16;

    localparam logic [15:0] VPP_MAX_DEFAULT = 16'd10000;
    localparam logic [15:0] FRE_MAX_DEFAULT = 16'd50000;
    localparam logic [15:0] MIN_DEFAULT     = 16'd0;

    typedef enum logic [1:0] {
        ERR_NONE    = 2'd0,
        ERR_CSUM    = 2'd1,
        ERR_RANGE   = 2'd2,
        ERR_TIMEOUT = 2'd3
    } err_code_e;

    typedef enum logic [2:0] {
        IDLE,
        HDR2,
        PAYLOAD,
        CSUM,
        CHECK,
        COMMIT
    } state_e;

    // Field order matches wire order, so the first payload byte lands in the MSBs.
    typedef struct packed {
        logic [15:0] vpp1_max;
        logic [15:0] vpp1_min;
        logic [15:0] fre1_max;
        logic [15:0] fre1_min;
        logic [15:0] vpp2_max;
        logic [15:0] vpp2_min;
        logic [15:0] fre2_max;
        logic [15:0] fre2_min;
    } limits_t;

    localparam limits_t LIMITS_RESET = '{
        vpp1_max: VPP_MAX_DEFAULT,
        vpp1_min: MIN_DEFAULT,
        fre1_max: FRE_MAX_DEFAULT,
        fre1_min: MIN_DEFAULT,
        vpp2_max: VPP_MAX_DEFAULT,
        vpp2_min: MIN_DEFAULT,
        fre2_max: FRE_MAX_DEFAULT,
        fre2_min: MIN_DEFAULT
    };

    function automatic logic range_ok(input limits_t l);
        return (l.vpp1_min <= l.vpp1_max) &&
               (l.fre1_min <= l.fre1_max) &&
               (l.vpp2_min <= l.vpp2_max) &&
               (l.fre2_min <= l.fre2_max);
    endfunction

endpackage

// File: rtl/limit_frame_rx_if.sv
// Byte-stream input and committed-limit outputs of the limit frame receiver.
interface limit_frame_rx_if;

    logic [7:0]  rx_data;
    logic        rx_valid;

    logic [15:0] Vpp1_max;
    logic [15:0] Vpp1_min;
    logic [15:0] fre1_max;
    logic [15:0] fre1_min;
    logic [15:0] Vpp2_max;
    logic [15:0] Vpp2_min;
    logic [15:0] fre2_max;
    logic [15:0] fre2_min;

    logic        upd;
    logic        err;
    logic [1:0]  err_code;
    logic        busy;

    modport master (
        output rx_data, rx_valid,
        input  Vpp1_max, Vpp1_min, fre1_max, fre1_min,
        input  Vpp2_max, Vpp2_min, fre2_max, fre2_min,
        input  upd, err, err_code, busy
    );

    modport slave (
        input  rx_data, rx_valid,
        output Vpp1_max, Vpp1_min, fre1_max, fre1_min,
        output Vpp2_max, Vpp2_min, fre2_max, fre2_min,
        output upd, err, err_code, busy
    );

endinterface

// File: rtl/gap_timer.sv
// Inter-byte gap counter: clears on demand or when disabled, saturates at
// TIMEOUT_CYC and flags the terminal count while enabled.
module gap_timer #(
    parameter int TIMEOUT_CYC = 5_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic i_en,
    input  logic i_clr,
    output logic o_tc
);

    localparam int               CNT_W    = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CNT_W-1:0] TERMINAL = CNT_W'(TIMEOUT_CYC);

    logic [CNT_W-1:0] r_cnt;

    // NOTE: sequential state is written only with <= so every flop samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst || !i_en || i_clr) begin
            r_cnt <= '0;
        end else if (r_cnt != TERMINAL) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign o_tc = i_en && !i_clr && (r_cnt == TERMINAL);

endmodule

// File: rtl/limit_frame_rx.sv
// Limit-command frame parser: header hunt, payload capture into a shadow buffer,
// checksum and min<=max validation, then an atomic commit of all eight limits.
module limit_frame_rx
    import limit_pkg::*;
#(
    parameter int TIMEOUT_CYC = 5_000_000
) (
    input  logic            clk,
    input  logic            rst,
    limit_frame_rx_if.slave bus
);

    localparam int             IDX_W    = $clog2(PAYLOAD_LEN);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PAYLOAD_LEN - 1);

    state_e           r_state;
    logic [IDX_W-1:0] r_idx;
    logic [7:0]       r_sum;
    logic [7:0]       r_shadow [PAYLOAD_LEN];
    limits_t          r_lim;
    logic             r_upd;
    logic             r_err;
    err_code_e        r_err_code;

    logic [PAYLOAD_LEN*8-1:0] w_shadow_bits;
    limits_t                  w_shadow_lim;
    logic                     w_timer_en;
    logic                     w_timeout;

    // NOTE: the default assignment before the loop keeps this block purely
    // combinational even if the loop bounds ever change.
    always_comb begin
        w_shadow_bits = '0;
        for (int i = 0; i < PAYLOAD_LEN; i++) begin
            w_shadow_bits[8*(PAYLOAD_LEN-1-i) +: 8] = r_shadow[i];
        end
    end

    assign w_shadow_lim = limits_t'(w_shadow_bits);
    assign w_timer_en   = (r_state == HDR2) || (r_state == PAYLOAD) || (r_state == CSUM);

    gap_timer #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_gap_timer (
        .clk   (clk),
        .rst   (rst),
        .i_en  (w_timer_en),
        .i_clr (bus.rx_valid),
        .o_tc  (w_timeout)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_idx      <= '0;
            r_sum      <= '0;
            // NOTE: the shadow buffer is small and must come out of reset
            // cleared, so it is built from resettable flops rather than RAM.
            for (int i = 0; i < PAYLOAD_LEN; i++) begin
                r_shadow[i] <= '0;
            end
            r_lim      <= LIMITS_RESET;
            r_upd      <= 1'b0;
            r_err      <= 1'b0;
            r_err_code <= ERR_NONE;
        end else begin
            r_upd <= 1'b0;
            r_err <= 1'b0;

            if (w_timeout) begin
                r_err      <= 1'b1;
                r_err_code <= ERR_TIMEOUT;
                r_state    <= IDLE;
            end else begin
                case (r_state)
                    IDLE: begin
                        if (bus.rx_valid && bus.rx_data == HDR0) begin
                            r_state <= HDR2;
                        end
                    end

                    // A repeated 0xAA may be the real start of a frame, so keep hunting.
                    HDR2: begin
                        if (bus.rx_valid) begin
                            if (bus.rx_data == HDR1) begin
                                r_idx   <= '0;
                                r_sum   <= '0;
                                r_state <= PAYLOAD;
                            end else if (bus.rx_data != HDR0) begin
                                r_state <= IDLE;
                            end
                        end
                    end

                    PAYLOAD: begin
                        if (bus.rx_valid) begin
                            r_shadow[r_idx] <= bus.rx_data;
                            r_sum           <= r_sum + bus.rx_data;
                            r_idx           <= r_idx + IDX_W'(1);
                            if (r_idx == LAST_IDX) begin
                                r_state <= CSUM;
                            end
                        end
                    end

                    CSUM: begin
                        if (bus.rx_valid) begin
                            if (bus.rx_data != r_sum) begin
                                r_err      <= 1'b1;
                                r_err_code <= ERR_CSUM;
                                r_state    <= IDLE;
                            end else begin
                                r_state <= CHECK;
                            end
                        end
                    end

                    // Limits load on leaving CHECK so they and upd are both visible in COMMIT.
                    CHECK: begin
                        if (range_ok(w_shadow_lim)) begin
                            r_lim   <= w_shadow_lim;
                            r_upd   <= 1'b1;
                            r_state <= COMMIT;
                        end else begin
                            r_err      <= 1'b1;
                            r_err_code <= ERR_RANGE;
                            r_state    <= IDLE;
                        end
                    end

                    COMMIT: r_state <= IDLE;

                    default: r_state <= IDLE;
                endcase
            end
        end
    end

    assign bus.Vpp1_max = r_lim.vpp1_max;
    assign bus.Vpp1_min = r_lim.vpp1_min;
    assign bus.fre1_max = r_lim.fre1_max;
    assign bus.fre1_min = r_lim.fre1_min;
    assign bus.Vpp2_max = r_lim.vpp2_max;
    assign bus.Vpp2_min = r_lim.vpp2_min;
    assign bus.fre2_max = r_lim.fre2_max;
    assign bus.fre2_min = r_lim.fre2_min;
    assign bus.upd      = r_upd;
    assign bus.err      = r_err;
    assign bus.err_code = r_err_code;
    assign bus.busy     = (r_state != IDLE);

endmodule

// File: tb/tb_limit_frame_rx.sv
// Directed bench for limit_frame_rx: commit timing, checksum/range/timeout
// rejection, header robustness and mid-frame reset.
module tb_limit_frame_rx;

    localparam logic [127:0] PAY_A   = 128'h1388_0064_4E20_03E8_1388_0064_4E20_03E8;
    localparam logic [7:0]   CSUM_A  = 8'hB0;
    localparam logic [127:0] PAY_B   = 128'h0BB8_0032_2710_01F4_0FA0_00C8_7530_07D0;
    localparam logic [7:0]   CSUM_B  = 8'h14;
    localparam logic [127:0] PAY_R   = 128'h1388_1389_4E20_03E8_1388_0064_4E20_03E8;
    localparam logic [7:0]   CSUM_R  = 8'hE8;
    localparam logic [127:0] LIM_RST = 128'h2710_0000_C350_0000_2710_0000_C350_0000;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks   = 0;
    int   failures = 0;
    int   upd_cnt  = 0;
    int   err_cnt  = 0;
    int   both_cnt = 0;

    limit_frame_rx_if bus ();

    limit_frame_rx #(
        .TIMEOUT_CYC (100)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        #1;
        if (bus.upd) upd_cnt++;
        if (bus.err) err_cnt++;
        if (bus.upd && bus.err) both_cnt++;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not reach the end");
        $fatal(1);
    end

    function automatic logic [127:0] lims();
        return {bus.Vpp1_max, bus.Vpp1_min, bus.fre1_max, bus.fre1_min,
                bus.Vpp2_max, bus.Vpp2_min, bus.fre2_max, bus.fre2_min};
    endfunction

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        bus.rx_data  = b;
        bus.rx_valid = 1'b1;
        @(negedge clk);
        bus.rx_valid = 1'b0;
    endtask

    task automatic send_payload_bytes(input logic [127:0] p, input int n);
        for (int i = 0; i < n; i++) send_byte(p[127-8*i -: 8]);
    endtask

    task automatic send_frame(input logic [127:0] p, input logic [7:0] c);
        send_byte(8'hAA);
        send_byte(8'h55);
        send_payload_bytes(p, 16);
        send_byte(c);
    endtask

    task automatic test_reset();
        bus.rx_data  = 8'h00;
        bus.rx_valid = 1'b0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        checks++; if (lims() !== LIM_RST) begin failures++; $display("FAIL reset_limits: got %h want %h", lims(), LIM_RST); end
        checks++; if ({bus.upd, bus.err, bus.err_code, bus.busy} !== 5'b0) begin failures++; $display("FAIL reset_flags: got upd=%b err=%b code=%0d busy=%b want all 0", bus.upd, bus.err, bus.err_code, bus.busy); end
    endtask

    task automatic test_bad_csum();
        int u0;
        u0 = upd_cnt;
        send_frame(PAY_A, 8'hB1);
        checks++; if (bus.err !== 1'b1) begin failures++; $display("FAIL csum_err_pulse: got %b want 1", bus.err); end
        checks++; if (bus.err_code !== 2'd1) begin failures++; $display("FAIL csum_err_code: got %0d want 1", bus.err_code); end
        @(negedge clk);
        checks++; if (bus.err !== 1'b0) begin failures++; $display("FAIL csum_err_width: got %b want 0", bus.err); end
        checks++; if (lims() !== LIM_RST) begin failures++; $display("FAIL csum_limits_kept: got %h want %h", lims(), LIM_RST); end
        checks++; if (upd_cnt !== u0) begin failures++; $display("FAIL csum_no_upd: got %0d upd pulses want 0", upd_cnt - u0); end
    endtask

    task automatic test_range_err();
        int u0;
        u0 = upd_cnt;
        send_frame(PAY_R, CSUM_R);
        checks++; if ({bus.err, bus.busy} !== 2'b01) begin failures++; $display("FAIL range_check_cycle: got err=%b busy=%b want err=0 busy=1", bus.err, bus.busy); end
        @(negedge clk);
        checks++; if (bus.err !== 1'b1) begin failures++; $display("FAIL range_err_pulse: got %b want 1", bus.err); end
        checks++; if (bus.err_code !== 2'd2) begin failures++; $display("FAIL range_err_code: got %0d want 2", bus.err_code); end
        @(negedge clk);
        checks++; if (lims() !== LIM_RST) begin failures++; $display("FAIL range_limits_kept: got %h want %h", lims(), LIM_RST); end
        checks++; if (upd_cnt !== u0) begin failures++; $display("FAIL range_no_upd: got %0d upd pulses want 0", upd_cnt - u0); end
    endtask

    task automatic test_valid();
        int e0;
        e0 = err_cnt;
        send_frame(PAY_A, CSUM_A);
        checks++; if ({bus.upd, bus.busy} !== 2'b01) begin failures++; $display("FAIL valid_check_cycle: got upd=%b busy=%b want upd=0 busy=1", bus.upd, bus.busy); end
        checks++; if (lims() !== LIM_RST) begin failures++; $display("FAIL valid_no_early_update: got %h want %h", lims(), LIM_RST); end
        @(negedge clk);
        checks++; if (bus.upd !== 1'b1) begin failures++; $display("FAIL valid_upd_pulse: got %b want 1", bus.upd); end
        checks++; if (lims() !== PAY_A) begin failures++; $display("FAIL valid_limits: got %h want %h", lims(), PAY_A); end
        @(negedge clk);
        checks++; if ({bus.upd, bus.busy} !== 2'b00) begin failures++; $display("FAIL valid_upd_width: got upd=%b busy=%b want both 0", bus.upd, bus.busy); end
        checks++; if (bus.err_code !== 2'd2) begin failures++; $display("FAIL valid_err_code_hold: got %0d want 2", bus.err_code); end
        checks++; if (err_cnt !== e0) begin failures++; $display("FAIL valid_no_err: got %0d err pulses want 0", err_cnt - e0); end
    endtask

    task automatic test_header();
        int u0;
        int e0;
        u0 = upd_cnt;
        send_byte(8'hAA);
        send_frame(PAY_B, CSUM_B);
        repeat (3) @(negedge clk);
        checks++; if (lims() !== PAY_B) begin failures++; $display("FAIL hdr_aa_aa_55_limits: got %h want %h", lims(), PAY_B); end
        checks++; if (upd_cnt !== u0 + 1) begin failures++; $display("FAIL hdr_aa_aa_55_upd: got %0d upd pulses want 1", upd_cnt - u0); end
        u0 = upd_cnt;
        e0 = err_cnt;
        send_byte(8'hAA);
        send_byte(8'h12);
        send_frame(PAY_A, CSUM_A);
        repeat (3) @(negedge clk);
        checks++; if (lims() !== PAY_A) begin failures++; $display("FAIL hdr_stray_limits: got %h want %h", lims(), PAY_A); end
        checks++; if (upd_cnt !== u0 + 1) begin failures++; $display("FAIL hdr_stray_upd: got %0d upd pulses want 1", upd_cnt - u0); end
        checks++; if (err_cnt !== e0) begin failures++; $display("FAIL hdr_stray_no_err: got %0d err pulses want 0", err_cnt - e0); end
    endtask

    task automatic wait_err(output int n, output logic seen);
        seen = 1'b0;
        n    = 0;
        for (int k = 1; k <= 300; k++) begin
            @(negedge clk);
            if (bus.err) begin
                seen = 1'b1;
                n    = k;
                break;
            end
        end
    endtask

    task automatic test_timeout();
        int   n;
        logic seen;
        send_byte(8'hAA);
        wait_err(n, seen);
        checks++; if (seen !== 1'b1) begin failures++; $display("FAIL hdr_stall_err: got no err in 300 cycles want err"); end
        checks++; if (bus.err_code !== 2'd3) begin failures++; $display("FAIL hdr_stall_code: got %0d want 3", bus.err_code); end
        send_byte(8'hAA);
        send_byte(8'h55);
        send_payload_bytes(PAY_B, 8);
        wait_err(n, seen);
        checks++; if (seen !== 1'b1) begin failures++; $display("FAIL payload_stall_err: got no err in 300 cycles want err"); end
        checks++; if (n < 100 || n > 102) begin failures++; $display("FAIL payload_stall_latency: got %0d cycles want 100..102", n); end
        checks++; if ({bus.err_code, bus.busy} !== 3'b110) begin failures++; $display("FAIL payload_stall_state: got code=%0d busy=%b want code=3 busy=0", bus.err_code, bus.busy); end
        send_frame(PAY_B, CSUM_B);
        repeat (2) @(negedge clk);
        checks++; if (lims() !== PAY_B) begin failures++; $display("FAIL after_timeout_limits: got %h want %h", lims(), PAY_B); end
    endtask

    task automatic test_reset_mid();
        send_byte(8'hAA);
        send_byte(8'h55);
        send_payload_bytes(PAY_A, 10);
        checks++; if (bus.busy !== 1'b1) begin failures++; $display("FAIL mid_busy: got %b want 1", bus.busy); end
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        checks++; if (lims() !== LIM_RST) begin failures++; $display("FAIL mid_reset_limits: got %h want %h", lims(), LIM_RST); end
        checks++; if ({bus.upd, bus.err, bus.err_code, bus.busy} !== 5'b0) begin failures++; $display("FAIL mid_reset_flags: got upd=%b err=%b code=%0d busy=%b want all 0", bus.upd, bus.err, bus.err_code, bus.busy); end
        send_frame(PAY_A, CSUM_A);
        repeat (2) @(negedge clk);
        checks++; if (lims() !== PAY_A) begin failures++; $display("FAIL after_reset_limits: got %h want %h", lims(), PAY_A); end
    endtask

    initial begin
        test_reset();
        test_bad_csum();
        test_range_err();
        test_valid();
        test_header();
        test_timeout();
        test_reset_mid();
        @(negedge clk);
        checks++; if (both_cnt !== 0) begin failures++; $display("FAIL upd_err_overlap: got %0d overlapping cycles want 0", both_cnt); end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/limit_frame_rx.md
# limit_frame_rx

Receive-side parser for the limit-setting command frame. It takes the byte stream from the UART receiver, hunts for the frame header, and assembles eight 16-bit limit fields into shadow registers. It checks the checksum and the min ≤ max constraints, and on success commits all eight limits at once with a one-cycle update pulse. Its outputs drive the first source-set inputs and the select flag of the limit selector ahead of the transmit path.

## Interface
- `TIMEOUT_CYC`, default 5_000_000: maximum allowed idle cycles between bytes inside a frame.
- `clk` in 1: system clock.
- `rst` in 1: reset. Synchronous, active-high.
- `rx_data` in 8: received byte.
- `rx_valid` in 1: one-cycle strobe, `rx_data` valid.
- `Vpp1_max`, `Vpp1_min`, `fre1_max`, `fre1_min`, `Vpp2_max`, `Vpp2_min`, `fre2_max`, `fre2_min` out 16 each: committed limits.
- `upd` out 1: one-cycle pulse when new limits are committed. Drives the selector flag.
- `err` out 1: one-cycle pulse when a frame is rejected.
- `err_code` out 2: reason for the rejection. 1 = checksum, 2 = range, 3 = timeout. Holds its value until the next `err`.
- `busy` out 1: high in every state except IDLE.

## Operation
- Frame layout, 19 bytes: 0xAA, 0x55, 16 payload bytes, checksum.
- Payload order: Vpp1_max, Vpp1_min, fre1_max, fre1_min, Vpp2_max, Vpp2_min, fre2_max, fre2_min. Each field is big-endian.
- Checksum: 8-bit sum (mod 256) of the 16 payload bytes.
- Range rule, all four must hold, unsigned compare:
  - Vpp1_min ≤ Vpp1_max
  - fre1_min ≤ fre1_max
  - Vpp2_min ≤ Vpp2_max
  - fre2_min ≤ fre2_max
- States and transitions:
  - IDLE: 0xAA → HDR2. Any other byte is ignored.
  - HDR2: 0x55 → PAYLOAD. 0xAA stays in HDR2. Any other byte → IDLE, with no `err`.
  - PAYLOAD: each byte goes into the shadow buffer at index `idx` (0..15), then `idx` increments. The 16th byte → CSUM.
  - CSUM: the byte is compared with the running sum. Mismatch → `err`, code 1, → IDLE. Match → CHECK.
  - CHECK: one cycle, range rule evaluated on the shadow buffer. Fail → `err`, code 2, → IDLE. Pass → COMMIT.
  - COMMIT: one cycle. Shadow buffer copied to the outputs, `upd` = 1, → IDLE.
- The running sum and `idx` are cleared on entry to PAYLOAD.
- The shadow buffer never drives the outputs directly. Outputs change only in COMMIT.
- Timeout:
  - The gap counter clears on every `rx_valid`. It counts only while state is HDR2, PAYLOAD or CSUM.
  - When it reaches `TIMEOUT_CYC`: `err`, code 3, → IDLE.
  - A header-only stall in HDR2 also reports code 3.
- `rx_valid` during CHECK or COMMIT: the byte is dropped. The UART byte period guarantees this cannot occur in a legal stream.
- Reset values:
  - Vpp1_max and Vpp2_max = 10000.
  - fre1_max and fre2_max = 50000.
  - All four mins = 0.
  - `upd` = 0, `err` = 0, `err_code` = 0, `busy` = 0.
  - State IDLE; shadow buffer, `idx` and sum cleared.
- Reset mid-frame: the partial frame is discarded and the outputs return to the reset values.

## Timing
- Checksum byte accepted at cycle N (registered in CSUM):
  - CHECK at N+1.
  - Outputs updated and `upd` high at N+2, for exactly one cycle.
- Checksum error: `err` high at N+1. Range error: `err` high at N+2.
- Timeout: `err` is asserted the cycle after the counter reaches `TIMEOUT_CYC`.
- `upd` and `err` are never high in the same cycle.
- Back-to-back frames need no gap beyond the normal UART byte spacing.

## Structure
- Shared package `limit_pkg` holds:
  - `HDR0` = 0xAA and `HDR1` = 0x55.
  - `PAYLOAD_LEN` = 16.
  - The reset-default constants (10000 / 50000 / 0).
  - The `err_code` enumeration.
  - The state enum: IDLE, HDR2, PAYLOAD, CSUM, CHECK, COMMIT.
- One sub-module: `gap_timer`, a clearable counter with a terminal-count pulse, parameterised by `TIMEOUT_CYC`.
- The FSM, shadow buffer and range comparators stay in the top module.

## Test plan
- Valid frame: AA 55 13 88 00 64 4E 20 03 E8 13 88 00 64 4E 20 03 E8, checksum B0.
  - `upd` pulses 2 cycles after B0.
  - Outputs become Vpp1_max = 5000, Vpp1_min = 100, fre1_max = 20000, fre1_min = 1000; Vpp2 and fre2 identical.
- Same frame with checksum B1 → `err`, `err_code` = 1. Outputs keep the reset defaults (10000/0/50000/0).
- Frame with Vpp1_min = 0x1389 and Vpp1_max = 0x1388, checksum recomputed → `err`, `err_code` = 2, no `upd`.
- Header robustness:
  - AA AA 55 followed by a valid payload → committed.
  - AA 12 followed by a valid frame → committed, no `err` for the stray byte.
- Timeout: with `TIMEOUT_CYC` = 100, stall 100 cycles after 8 payload bytes → `err`, `err_code` = 3, `busy` = 0. A following valid frame commits normally.
- Reset mid-payload: assert `rst` after 10 payload bytes → outputs equal the reset values. A subsequent valid frame commits.
